wb_sched: RTL

Writeback scheduler and scoreboard for the integer register file. Shares the register file's single write port between the ALU and load/store unit (LSU) writeback paths. Tracks destination registers with outstanding writes and stalls issue on RAW/WAW hazards. Sits between the execute/memory stages and the register file's Rd_Addr/Rd_Data inputs.

---
 rtl/wb_sched.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_sched.sv
// Writeback arbiter and register scoreboard sharing the register-file write port between ALU and LSU.
// Optional feature macro WB_RR_ARB_EN: round-robin arbitration instead of fixed LSU-over-ALU priority.
module wb_sched (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        Issue_Valid,
  input  logic [4:0]  Issue_Rd,
  input  logic [4:0]  Issue_Rs1,
  input  logic [4:0]  Issue_Rs2,
  output logic        Issue_Stall,
  input  logic        Alu_Valid,
  input  logic [4:0]  Alu_Rd,
  input  logic [31:0] Alu_Data,
  output logic        Alu_Ready,
  input  logic        Lsu_Valid,
  input  logic [4:0]  Lsu_Rd,
  input  logic [31:0] Lsu_Data,
  output logic        Lsu_Ready,
  output logic [4:0]  Rd_Addr,
  output logic [31:0] Rd_Data,
  output logic [31:0] Pending,
  output logic        Wb_Err
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          alu_gnt;
  logic          lsu_gnt;
  logic          xfer;
  logic [AW-1:0] xfer_rd;
  logic [DW-1:0] xfer_data;
  logic          issue_take;
  logic [DW-1:0] pending_d;

  // Source r is unsafe while its write is outstanding or still sitting in the output stage.
  function automatic logic hazard(input logic [AW-1:0] r,
                                  input logic [DW-1:0] pend,
                                  input logic [AW-1:0] stage_addr);
    return (r != AW'(0)) && (pend[r] || (stage_addr == r));
  endfunction

`ifdef WB_RR_ARB_EN
  logic alu_next;  // set: ALU wins the next contended cycle

  always_comb begin
    lsu_gnt = Lsu_Valid && (!Alu_Valid || !alu_next);
    alu_gnt = Alu_Valid && (!Lsu_Valid || alu_next);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      alu_next <= 1'b1;
    end else if (Alu_Valid && Lsu_Valid) begin
      alu_next <= lsu_gnt;
    end
  end
`else
  always_comb begin
    lsu_gnt = Lsu_Valid;
    alu_gnt = Alu_Valid && !Lsu_Valid;
  end
`endif

  assign Alu_Ready = alu_gnt;
  assign Lsu_Ready = lsu_gnt;

  // Select the granted payload; idle cycles present x0 so the register file discards the write.
  always_comb begin
    xfer      = alu_gnt || lsu_gnt;
    xfer_rd   = AW'(0);
    xfer_data = DW'(0);
    if (lsu_gnt) begin
      xfer_rd   = Lsu_Rd;
      xfer_data = Lsu_Data;
    end else if (alu_gnt) begin
      xfer_rd   = Alu_Rd;
      xfer_data = Alu_Data;
    end
  end

  always_comb begin
    Issue_Stall = Issue_Valid &&
                  (hazard(Issue_Rs1, Pending, Rd_Addr) ||
                   hazard(Issue_Rs2, Pending, Rd_Addr) ||
                   Pending[Issue_Rd]);
    issue_take  = Issue_Valid && !Issue_Stall && (Issue_Rd != AW'(0));
  end

  // Set and clear never target the same register on one edge: a pending destination stalls issue.
  always_comb begin
    pending_d = Pending;
    if (issue_take) begin
      pending_d[Issue_Rd] = 1'b1;
    end
    if (xfer) begin
      pending_d[xfer_rd] = 1'b0;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      Rd_Addr <= AW'(0);
      Rd_Data <= DW'(0);
      Pending <= DW'(0);
      Wb_Err  <= 1'b0;
    end else begin
      Rd_Addr <= xfer_rd;
      Rd_Data <= xfer_data;
      Pending <= pending_d;
      if (xfer && (xfer_rd != AW'(0)) && !Pending[xfer_rd]) begin
        Wb_Err <= 1'b1;
      end
    end
  end

endmodule
